// File: rtl/sequence_player.sv
// Genius sequence playback: fetches play_len color codes from RAM starting at 0
// and flashes the matching LED for an on-period, then blanks for an off-period.
module sequence_player #(
    parameter int COLOR_CODEFY_W = 2,
    parameter int ADDR_WIDTH     = 5,
    parameter int ON_SLOW        = 8,
    parameter int OFF_SLOW       = 4,
    parameter int ON_FAST        = 4,
    parameter int OFF_FAST       = 2,
    parameter int CNT_W          = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      play_start,
    input  logic [ADDR_WIDTH:0]       play_len,
    input  logic                      speed,
    input  logic                      abort,
    output logic                      mem_rd_en,
    output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
    input  logic [COLOR_CODEFY_W-1:0] mem_rd_data,
    output logic                      led_green,
    output logic                      led_red,
    output logic                      led_blue,
    output logic                      led_yellow,
    output logic                      busy,
    output logic                      done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ON    = 3'd3;
    localparam logic [2:0] S_OFF   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [CNT_W-1:0]    ON_S    = CNT_W'(ON_SLOW);
    localparam logic [CNT_W-1:0]    OFF_S   = CNT_W'(OFF_SLOW);
    localparam logic [CNT_W-1:0]    ON_F    = CNT_W'(ON_FAST);
    localparam logic [CNT_W-1:0]    OFF_F   = CNT_W'(OFF_FAST);

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] index;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic [CNT_W-1:0]      cnt;
    logic                  spd;
    logic [3:0]            leds;
    logic [ADDR_WIDTH:0]   len_clamped;
    logic [ADDR_WIDTH:0]   len_m1;

    // Clamp keeps the index from ever wrapping; last index fits in ADDR_WIDTH bits.
    assign len_clamped = (play_len > MAX_LEN) ? MAX_LEN : play_len;
    assign len_m1      = len_clamped - (ADDR_WIDTH+1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            index    <= '0;
            last_idx <= '0;
            cnt      <= '0;
            spd      <= 1'b0;
            leds     <= '0;
        end else if (abort && state != S_IDLE) begin
            state <= S_IDLE;
            leds  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (play_start && !abort) begin
                        if (play_len != '0) begin
                            state    <= S_FETCH;
                            spd      <= speed;
                            last_idx <= len_m1[ADDR_WIDTH-1:0];
                            index    <= '0;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_FETCH: state <= S_WAIT;
                S_WAIT: begin
                    leds  <= 4'd1 << mem_rd_data;
                    cnt   <= spd ? ON_F : ON_S;
                    state <= S_ON;
                end
                S_ON: begin
                    if (cnt == CNT_W'(1)) begin
                        leds  <= '0;
                        cnt   <= spd ? OFF_F : OFF_S;
                        state <= S_OFF;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_OFF: begin
                    if (cnt == CNT_W'(1)) begin
                        if (index == last_idx) begin
                            state <= S_DONE;
                        end else begin
                            index <= index + ADDR_WIDTH'(1);
                            state <= S_FETCH;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_rd_en   = (state == S_FETCH);
    assign mem_rd_addr = index;
    assign busy        = (state == S_FETCH) || (state == S_WAIT) ||
                         (state == S_ON)    || (state == S_OFF);
    assign done        = (state == S_DONE);
    assign led_green   = leds[0];
    assign led_red     = leds[1];
    assign led_blue    = leds[2];
    assign led_yellow  = leds[3];

endmodule
